instr_prefetch: RTL and testbench

- Instruction fetch front end sitting directly upstream of the single-cycle ARM datapath; supplies its `instr` input.
- Generates sequential word addresses and fetches from instruction memory over a req/ack handshake.
- Buffers fetched words in a small prefetch FIFO, tagging each with its PC.
- On a taken branch or PC write, flushes the FIFO and restarts fetching at the redirect target.

---
 rtl/instr_prefetch.sv | 118 +++++++++++
 tb/tb_instr_prefetch.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/instr_prefetch.sv
// Instruction fetch front end: sequential req/ack fetch into a PC-tagged
// prefetch FIFO, with flush-and-restart on redirect.
module instr_prefetch #(
  parameter int unsigned DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  output logic        instr_valid,
  input  logic        instr_ready
);

  localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = PW + 1;

  typedef enum logic {S_BUBBLE = 1'b0, S_RUN = 1'b1} state_e;

  state_e         state_q, state_d;
  logic [31:0]    fetch_pc_q, fetch_pc_d;
  logic [CW-1:0]  count_q, count_d;
  logic [PW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [31:0]    data_q [DEPTH];
  logic [31:0]    pc_q   [DEPTH];
  logic [31:0]    hold_instr_q, hold_pc_q;
  logic           push, pop, wr_en;

  assign imem_req    = (state_q == S_RUN) && (count_q < CW'(DEPTH));
  assign imem_addr   = fetch_pc_q;
  assign instr_valid = (count_q != '0);
  assign push        = imem_req && imem_ack;
  assign pop         = instr_valid && instr_ready;
  assign wr_en       = push && !redirect;

  // Empty FIFO shows the last head seen rather than stale slot contents.
  assign instr    = instr_valid ? data_q[rd_ptr_q] : hold_instr_q;
  assign instr_pc = instr_valid ? pc_q[rd_ptr_q]   : hold_pc_q;

  // Next-state: redirect overrides any beat or pop in the same cycle.
  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    count_d    = count_q;
    rd_ptr_d   = rd_ptr_q;
    wr_ptr_d   = wr_ptr_q;
    case (state_q)
      S_BUBBLE: state_d = S_RUN;
      S_RUN:    state_d = S_RUN;
      default:  state_d = S_BUBBLE;
    endcase
    if (redirect) begin
      state_d    = S_BUBBLE;
      fetch_pc_d = {redirect_pc[31:2], 2'b00};
      count_d    = '0;
      rd_ptr_d   = '0;
      wr_ptr_d   = '0;
    end else begin
      if (push) begin
        wr_ptr_d   = wr_ptr_q + PW'(1);
        fetch_pc_d = fetch_pc_q + 32'd4;
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      if (push && !pop) begin
        count_d = count_q + CW'(1);
      end else if (pop && !push) begin
        count_d = count_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= S_BUBBLE;
      fetch_pc_q <= RESET_PC;
      count_q    <= '0;
      rd_ptr_q   <= '0;
      wr_ptr_q   <= '0;
    end else begin
      state_q    <= state_d;
      fetch_pc_q <= fetch_pc_d;
      count_q    <= count_d;
      rd_ptr_q   <= rd_ptr_d;
      wr_ptr_q   <= wr_ptr_d;
    end
  end

  // FIFO storage and head-hold registers, all cleared on reset.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < int'(DEPTH); i++) begin
        data_q[i] <= '0;
        pc_q[i]   <= '0;
      end
      hold_instr_q <= '0;
      hold_pc_q    <= '0;
    end else begin
      if (wr_en) begin
        data_q[wr_ptr_q] <= imem_rdata;
        pc_q[wr_ptr_q]   <= fetch_pc_q;
      end
      if (instr_valid) begin
        hold_instr_q <= data_q[rd_ptr_q];
        hold_pc_q    <= pc_q[rd_ptr_q];
      end
    end
  end

endmodule

// File: tb/tb_instr_prefetch.sv
// Directed bench for instr_prefetch: stream, fill/full, slow memory,
// redirect, address wrap and asynchronous reset.
module tb_instr_prefetch;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_valid;
  logic        instr_ready;

  int n_assert = 0;
  int n_fail   = 0;

  localparam logic [31:0] KEY = 32'hA5A5_0000;

  instr_prefetch #(.DEPTH(4), .RESET_PC(32'h0000_0000)) dut (
    .clk         (clk),
    .reset       (reset),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_ack    (imem_ack),
    .imem_rdata  (imem_rdata),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .instr       (instr),
    .instr_pc    (instr_pc),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready)
  );

  // Memory returns a word derived from its address.
  assign imem_rdata = imem_addr ^ KEY;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    logic [31:0] exp_addr;
    logic [31:0] exp_out;
    logic        beat;

    reset       = 1'b0;
    imem_ack    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    instr_ready = 1'b0;
    #2;
    chk("rst_req",   32'(imem_req), 32'd0);
    chk("rst_addr",  imem_addr, 32'h0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_pc",    instr_pc, 32'h0);
    tick();

    // Stream: ack and ready always high
    imem_ack    = 1'b1;
    instr_ready = 1'b1;
    @(negedge clk) reset = 1'b1;
    tick();
    chk("s_req_e1",   32'(imem_req), 32'd1);
    chk("s_valid_e1", 32'(instr_valid), 32'd0);
    chk("s_addr_e1",  imem_addr, 32'h0);
    tick();
    chk("s_valid_e2", 32'(instr_valid), 32'd1);
    chk("s_pc_e2",    instr_pc, 32'h0);
    chk("s_instr_e2", instr, 32'h0 ^ KEY);
    chk("s_addr_e2",  imem_addr, 32'h4);
    tick();
    chk("s_pc_e3",    instr_pc, 32'h4);
    chk("s_instr_e3", instr, 32'h4 ^ KEY);
    chk("s_addr_e3",  imem_addr, 32'h8);
    tick();
    chk("s_pc_e4",    instr_pc, 32'h8);
    chk("s_instr_e4", instr, 32'h8 ^ KEY);

    // Fill/full: restart at 0 with consumer stalled
    instr_ready = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0;
    tick();
    redirect = 1'b0;
    chk("f_bub_req",   32'(imem_req), 32'd0);
    chk("f_bub_valid", 32'(instr_valid), 32'd0);
    tick();
    chk("f_run_req", 32'(imem_req), 32'd1);
    for (int i = 0; i < 4; i++) tick();
    chk("f_full_req",  32'(imem_req), 32'd0);
    chk("f_full_addr", imem_addr, 32'h10);
    chk("f_full_pc",   instr_pc, 32'h0);
    tick();
    chk("f_hold_req",  32'(imem_req), 32'd0);
    chk("f_hold_addr", imem_addr, 32'h10);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    chk("f_pop_req",  32'(imem_req), 32'd1);
    chk("f_pop_addr", imem_addr, 32'h10);
    chk("f_pop_pc",   instr_pc, 32'h4);
    tick();
    chk("f_refill_req",  32'(imem_req), 32'd0);
    chk("f_refill_addr", imem_addr, 32'h14);

    // Redirect coinciding with beat and pop, 3 entries buffered
    instr_ready = 1'b1;
    tick();
    chk("r_pre_req", 32'(imem_req), 32'd1);
    chk("r_pre_pc",  instr_pc, 32'h8);
    redirect    = 1'b1;
    redirect_pc = 32'h0000_1003;
    tick();
    redirect = 1'b0;
    chk("r_t1_req",   32'(imem_req), 32'd0);
    chk("r_t1_valid", 32'(instr_valid), 32'd0);
    chk("r_t1_addr",  imem_addr, 32'h1000);
    tick();
    chk("r_t2_req",   32'(imem_req), 32'd1);
    chk("r_t2_addr",  imem_addr, 32'h1000);
    chk("r_t2_valid", 32'(instr_valid), 32'd0);
    tick();
    chk("r_out_valid", 32'(instr_valid), 32'd1);
    chk("r_out_pc",    instr_pc, 32'h1000);
    chk("r_out_instr", instr, 32'h1000 ^ KEY);

    // Slow memory: ack every third cycle
    imem_ack    = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    redirect = 1'b0;
    tick();
    exp_addr = 32'h200;
    exp_out  = 32'h200;
    for (int i = 0; i < 9; i++) begin
      beat     = (i % 3 == 2);
      imem_ack = beat;
      chk("m_req", 32'(imem_req), 32'd1);
      tick();
      if (beat) exp_addr = exp_addr + 32'd4;
      chk("m_addr", imem_addr, exp_addr);
      if (beat) begin
        chk("m_valid", 32'(instr_valid), 32'd1);
        chk("m_pc",    instr_pc, exp_out);
        chk("m_instr", instr, exp_out ^ KEY);
        exp_out = exp_out + 32'd4;
      end else begin
        chk("m_idle", 32'(instr_valid), 32'd0);
      end
    end

    // Back-to-back redirects: last target wins
    imem_ack    = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0300;
    tick();
    redirect_pc = 32'h0000_0402;
    tick();
    redirect = 1'b0;
    chk("b_req",  32'(imem_req), 32'd0);
    chk("b_addr", imem_addr, 32'h400);
    tick();
    chk("b_req2",  32'(imem_req), 32'd1);
    chk("b_addr2", imem_addr, 32'h400);

    // Wrap past the top of the address space
    redirect    = 1'b1;
    redirect_pc = 32'hFFFF_FFF8;
    tick();
    redirect = 1'b0;
    tick();
    chk("w_addr0", imem_addr, 32'hFFFF_FFF8);
    exp_out = 32'hFFFF_FFF8;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("w_pc",   instr_pc, exp_out);
      chk("w_data", instr, exp_out ^ KEY);
      exp_out = exp_out + 32'd4;
    end

    // Async reset mid-beat with 2 entries buffered
    instr_ready = 1'b0;
    redirect    = 1'b1;
    redirect_pc = 32'h0000_0500;
    tick();
    redirect = 1'b0;
    tick();
    tick();
    tick();
    chk("a_pre_req",   32'(imem_req), 32'd1);
    chk("a_pre_valid", 32'(instr_valid), 32'd1);
    chk("a_pre_addr",  imem_addr, 32'h508);
    #2 reset = 1'b0;
    #1;
    chk("a_req",   32'(imem_req), 32'd0);
    chk("a_valid", 32'(instr_valid), 32'd0);
    chk("a_addr",  imem_addr, 32'h0);
    chk("a_instr", instr, 32'h0);
    chk("a_pc",    instr_pc, 32'h0);
    tick();
    chk("a_held_addr", imem_addr, 32'h0);
    chk("a_held_req",  32'(imem_req), 32'd0);
    instr_ready = 1'b1;
    @(negedge clk) reset = 1'b1;
    tick();
    chk("a_rel_req",   32'(imem_req), 32'd1);
    chk("a_rel_valid", 32'(instr_valid), 32'd0);
    tick();
    chk("a_rel_pc",   instr_pc, 32'h0);
    chk("a_rel_addr", imem_addr, 32'h4);
    tick();
    chk("a_rel_pc2",  instr_pc, 32'h4);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
